// File: rtl/multi_issue_branch_predictor.sv
// ---------------------------------------------------------------------------
// multi_issue_branch_predictor
//
// Purpose: N-lane branch direction predictor. Every cycle fetch presents
// ISSUE_WIDTH PCs and receives one taken/not-taken prediction per lane,
// combinationally. Execute returns resolved outcomes, which train a table of
// 2-bit saturating counters and a global history register (GHR). Indexing is
// bimodal (pc low bits) or gshare (pc low bits XOR history).
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   enable         1 = updates allowed, 0 = hold all state
//   lookup_pc      lane i fetch PC at [i*PC_WIDTH +: PC_WIDTH]
//   prediction     lane i: 1 = predict taken (same cycle, no bypass)
//   upd_valid      lane i resolved a conditional branch this cycle
//   upd_pc         PC of the resolved branch per lane
//   upd_taken      actual outcome per lane
//   upd_mispred    prediction was wrong, per lane (ignored when not valid)
//   ghr            global history, bit 0 = newest outcome
//   mispred_count  total mispredicts since reset, wraps at 2^32
//
// Interface semantics: there is no handshake. upd_valid is a single-cycle
// qualifier sampled on the rising edge when enable=1; the block never
// back-pressures, so every valid lane is consumed on that edge.
// ---------------------------------------------------------------------------
module multi_issue_branch_predictor #(
  parameter int ISSUE_WIDTH = 2,
  parameter int PC_WIDTH    = 11,
  parameter int TABLE_DEPTH = 64,
  parameter int GHR_BITS    = 6,
  parameter int GSHARE      = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable,
  input  logic [ISSUE_WIDTH*PC_WIDTH-1:0] lookup_pc,
  output logic [ISSUE_WIDTH-1:0]          prediction,
  input  logic [ISSUE_WIDTH-1:0]          upd_valid,
  input  logic [ISSUE_WIDTH*PC_WIDTH-1:0] upd_pc,
  input  logic [ISSUE_WIDTH-1:0]          upd_taken,
  input  logic [ISSUE_WIDTH-1:0]          upd_mispred,
  output logic [GHR_BITS-1:0]             ghr,
  output logic [31:0]                     mispred_count
);

  localparam int IDX_W = $clog2(TABLE_DEPTH);

  logic [1:0]          cnt_q [TABLE_DEPTH];
  logic [1:0]          cnt_d [TABLE_DEPTH];
  logic [GHR_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         mispred_count_q, mispred_count_d;

  logic [IDX_W-1:0]    lookup_idx [ISSUE_WIDTH];
  logic [IDX_W-1:0]    upd_idx    [ISSUE_WIDTH];

  // Both lookup and update hash with the registered history: later lanes of
  // an update bundle do not see the history bits shifted in by earlier lanes.
  function automatic logic [IDX_W-1:0] make_idx(input logic [PC_WIDTH-1:0] pc,
                                                input logic [GHR_BITS-1:0] h);
    logic [IDX_W-1:0] base;
    base = pc[IDX_W-1:0];
    if (GSHARE != 0) make_idx = base ^ IDX_W'(h);
    else             make_idx = base;
  endfunction

  always_comb begin
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      lookup_idx[i] = make_idx(lookup_pc[i*PC_WIDTH +: PC_WIDTH], ghr_q);
      upd_idx[i]    = make_idx(upd_pc[i*PC_WIDTH +: PC_WIDTH], ghr_q);
    end
  end

  // Prediction reads the registered table only, so a same-cycle update to the
  // same entry is not visible until the next cycle.
  always_comb begin
    prediction = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) begin
      prediction[i] = cnt_q[lookup_idx[i]][1];
    end
  end

  // Lanes are folded in order 0..N-1 on top of the running cnt_d, so several
  // lanes hitting one entry accumulate exactly as sequential updates would.
  always_comb begin
    cnt_d           = cnt_q;
    ghr_d           = ghr_q;
    mispred_count_d = mispred_count_q;
    if (enable) begin
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
        if (upd_valid[i]) begin
          if (upd_taken[i]) begin
            if (cnt_d[upd_idx[i]] != 2'b11) cnt_d[upd_idx[i]] = cnt_d[upd_idx[i]] + 2'b01;
          end else begin
            if (cnt_d[upd_idx[i]] != 2'b00) cnt_d[upd_idx[i]] = cnt_d[upd_idx[i]] - 2'b01;
          end
          // Shift form works for GHR_BITS=1 as well as wider histories.
          ghr_d = (ghr_d << 1) | GHR_BITS'(upd_taken[i]);
          if (upd_mispred[i]) mispred_count_d = mispred_count_d + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < TABLE_DEPTH; e++) cnt_q[e] <= 2'b01;
      ghr_q           <= '0;
      mispred_count_q <= '0;
    end else begin
      for (int e = 0; e < TABLE_DEPTH; e++) cnt_q[e] <= cnt_d[e];
      ghr_q           <= ghr_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign ghr           = ghr_q;
  assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_multi_issue_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_multi_issue_branch_predictor
//
// Drives a bimodal instance and a gshare instance from the same stimulus and
// checks them against hand-computed expectations. Inputs change on the
// falling edge; outputs are sampled on the falling edge after each update.
// ---------------------------------------------------------------------------
module tb_multi_issue_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [21:0] lookup_pc;
  logic [1:0]  upd_valid;
  logic [21:0] upd_pc;
  logic [1:0]  upd_taken;
  logic [1:0]  upd_mispred;

  logic [1:0]  pred_b, pred_g;
  logic [5:0]  ghr_b, ghr_g;
  logic [31:0] cnt_b, cnt_g;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  multi_issue_branch_predictor #(
    .ISSUE_WIDTH(2), .PC_WIDTH(11), .TABLE_DEPTH(64), .GHR_BITS(6), .GSHARE(0)
  ) dut_bim (
    .clk(clk), .rst(rst), .enable(enable), .lookup_pc(lookup_pc),
    .prediction(pred_b), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred), .ghr(ghr_b),
    .mispred_count(cnt_b)
  );

  multi_issue_branch_predictor #(
    .ISSUE_WIDTH(2), .PC_WIDTH(11), .TABLE_DEPTH(64), .GHR_BITS(6), .GSHARE(1)
  ) dut_gsh (
    .clk(clk), .rst(rst), .enable(enable), .lookup_pc(lookup_pc),
    .prediction(pred_g), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred), .ghr(ghr_g),
    .mispred_count(cnt_g)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    upd_valid = '0; upd_taken = '0; upd_mispred = '0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- driver ----------------
  // One update bundle for one clock edge, then valid drops again.
  task automatic drive_upd(input logic [1:0] v, input logic [10:0] pc1,
                           input logic [10:0] pc0, input logic [1:0] t,
                           input logic [1:0] m);
    @(negedge clk);
    upd_valid = v; upd_pc = {pc1, pc0}; upd_taken = t; upd_mispred = m;
    @(negedge clk);
    upd_valid = '0; upd_taken = '0; upd_mispred = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; enable = 1'b1;
    lookup_pc = {11'd5, 11'd4};
    upd_valid = '0; upd_pc = '0; upd_taken = '0; upd_mispred = '0;
    #12;
    checks++;
    if (pred_b !== 2'b00) begin errors++; $display("FAIL reset_during_pred got=%b exp=00", pred_b); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if (pred_b !== 2'b00) begin errors++; $display("FAIL reset_pred got=%b exp=00", pred_b); end
    checks++;
    if (ghr_b !== 6'd0) begin errors++; $display("FAIL reset_ghr got=%b exp=000000", ghr_b); end
    checks++;
    if (cnt_b !== 32'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cnt_b); end
  endtask

  task automatic test_bimodal();
    logic [1:0] exp_pred [7];
    int k;
    // lane0 looks up pc 4 (entry 4 starts at 1); lane1 pc 5 stays untouched.
    exp_pred = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
    lookup_pc = {11'd5, 11'd4};
    k = 0;
    drive_upd(2'b01, 11'd0, 11'd4, 2'b01, 2'b00);            // c=2
    checks++;
    if (pred_b !== exp_pred[k]) begin errors++; $display("FAIL bim_t1 got=%b exp=%b", pred_b, exp_pred[k]); end
    k++;
    drive_upd(2'b01, 11'd0, 11'd4, 2'b01, 2'b00);            // c=3
    drive_upd(2'b01, 11'd0, 11'd4, 2'b01, 2'b00);            // c=3 saturate
    checks++;
    if (pred_b !== exp_pred[k]) begin errors++; $display("FAIL bim_t3_sat got=%b exp=%b", pred_b, exp_pred[k]); end
    k++;
    drive_upd(2'b01, 11'd0, 11'd4, 2'b00, 2'b00);            // c=2
    checks++;
    if (pred_b !== exp_pred[k]) begin errors++; $display("FAIL bim_nt1 got=%b exp=%b", pred_b, exp_pred[k]); end
    k++;
    drive_upd(2'b01, 11'd0, 11'd4, 2'b00, 2'b00);            // c=1
    checks++;
    if (pred_b !== exp_pred[k]) begin errors++; $display("FAIL bim_nt2 got=%b exp=%b", pred_b, exp_pred[k]); end
    k++;
    drive_upd(2'b01, 11'd0, 11'd4, 2'b00, 2'b00);            // c=0
    drive_upd(2'b01, 11'd0, 11'd4, 2'b00, 2'b00);            // c=0 floor
    checks++;
    if (pred_b !== exp_pred[k]) begin errors++; $display("FAIL bim_nt4_floor got=%b exp=%b", pred_b, exp_pred[k]); end
    k++;
    drive_upd(2'b01, 11'd0, 11'd4, 2'b01, 2'b00);            // c=1
    checks++;
    if (pred_b !== exp_pred[k]) begin errors++; $display("FAIL bim_recover1 got=%b exp=%b", pred_b, exp_pred[k]); end
    k++;
    drive_upd(2'b01, 11'd0, 11'd4, 2'b01, 2'b00);            // c=2
    checks++;
    if (pred_b !== exp_pred[k]) begin errors++; $display("FAIL bim_recover2 got=%b exp=%b", pred_b, exp_pred[k]); end
  endtask

  task automatic test_merge();
    lookup_pc = {11'd5, 11'd7};
    // Both lanes hit entry 7 (c=1); before the edge the lookup sees c=1.
    @(negedge clk);
    upd_valid = 2'b11; upd_pc = {11'd7, 11'd7}; upd_taken = 2'b11; upd_mispred = 2'b00;
    #1;
    checks++;
    if (pred_b !== 2'b00) begin errors++; $display("FAIL merge_no_bypass got=%b exp=00", pred_b); end
    @(negedge clk);
    upd_valid = '0; upd_taken = '0;
    checks++;
    if (pred_b !== 2'b01) begin errors++; $display("FAIL merge_tt got=%b exp=01", pred_b); end  // c=3
    drive_upd(2'b11, 11'd7, 11'd7, 2'b00, 2'b00);            // c=1
    checks++;
    if (pred_b !== 2'b00) begin errors++; $display("FAIL merge_nn got=%b exp=00", pred_b); end
    drive_upd(2'b11, 11'd7, 11'd7, 2'b01, 2'b00);            // lane0 T, lane1 NT: c=1
    checks++;
    if (pred_b !== 2'b00) begin errors++; $display("FAIL merge_tn got=%b exp=00", pred_b); end
    drive_upd(2'b01, 11'd0, 11'd7, 2'b01, 2'b00);            // c=2 proves it held at 1
    checks++;
    if (pred_b !== 2'b01) begin errors++; $display("FAIL merge_after_tn got=%b exp=01", pred_b); end
  endtask

  task automatic test_ghr_order();
    apply_reset();
    drive_upd(2'b11, 11'd31, 11'd30, 2'b01, 2'b00);          // shift 1 then 0
    checks++;
    if (ghr_b !== 6'b000010) begin errors++; $display("FAIL ghr_two_lanes got=%b exp=000010", ghr_b); end
    drive_upd(2'b10, 11'd31, 11'd0, 2'b10, 2'b00);           // only lane1 shifts
    checks++;
    if (ghr_b !== 6'b000101) begin errors++; $display("FAIL ghr_lane1_only got=%b exp=000101", ghr_b); end
  endtask

  task automatic test_gating();
    enable = 1'b0;
    drive_upd(2'b11, 11'd4, 11'd4, 2'b11, 2'b11);
    checks++;
    if (ghr_b !== 6'b000101) begin errors++; $display("FAIL gate_ghr got=%b exp=000101", ghr_b); end
    checks++;
    if (cnt_b !== 32'd0) begin errors++; $display("FAIL gate_count got=%0d exp=0", cnt_b); end
    lookup_pc = {11'd4, 11'd4};
    #1;
    checks++;
    if (pred_b !== 2'b00) begin errors++; $display("FAIL gate_table got=%b exp=00", pred_b); end
    // entry 30 = 2 (taken once), entry 31 = 1; lookup stays live while gated.
    lookup_pc = {11'd31, 11'd30};
    #1;
    checks++;
    if (pred_b !== 2'b01) begin errors++; $display("FAIL gate_pred_live got=%b exp=01", pred_b); end
    enable = 1'b1;
    drive_upd(2'b11, 11'd41, 11'd40, 2'b00, 2'b11);
    checks++;
    if (cnt_b !== 32'd2) begin errors++; $display("FAIL count_plus2 got=%0d exp=2", cnt_b); end
    drive_upd(2'b01, 11'd0, 11'd40, 2'b00, 2'b11);           // lane1 mispred ignored
    checks++;
    if (cnt_b !== 32'd3) begin errors++; $display("FAIL count_invalid_lane got=%0d exp=3", cnt_b); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    upd_valid = 2'b11; upd_pc = {11'd41, 11'd40}; upd_taken = 2'b11; upd_mispred = 2'b11;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (cnt_b !== 32'd0 || ghr_b !== 6'd0) begin
      errors++; $display("FAIL mid_reset_async count=%0d ghr=%b exp=0/000000", cnt_b, ghr_b);
    end
    @(negedge clk);
    checks++;
    if (cnt_b !== 32'd0) begin errors++; $display("FAIL mid_reset_held got=%0d exp=0", cnt_b); end
    rst = 1'b1;
    upd_valid = '0; upd_taken = '0; upd_mispred = '0;
  endtask

  task automatic test_gshare();
    apply_reset();
    lookup_pc = {11'd11, 11'd8};
    drive_upd(2'b11, 11'd21, 11'd20, 2'b11, 2'b00);          // ghr 000011
    checks++;
    if (ghr_g !== 6'b000011) begin errors++; $display("FAIL gsh_ghr3 got=%b exp=000011", ghr_g); end
    drive_upd(2'b11, 11'd8, 11'd8, 2'b11, 2'b00);            // both lanes -> entry 11 = 3
    // Shift in 0,0,0,0,1,1 with pc 0 (entries 15, 60, 48) to return to ghr 3.
    drive_upd(2'b11, 11'd0, 11'd0, 2'b00, 2'b00);
    drive_upd(2'b11, 11'd0, 11'd0, 2'b00, 2'b00);
    drive_upd(2'b11, 11'd0, 11'd0, 2'b11, 2'b00);
    checks++;
    if (ghr_g !== 6'b000011) begin errors++; $display("FAIL gsh_ghr_back3 got=%b exp=000011", ghr_g); end
    // lane0 pc8 -> entry 11 (3), lane1 pc11 -> entry 8 (1)
    checks++;
    if (pred_g !== 2'b01) begin errors++; $display("FAIL gsh_pred_ghr3 got=%b exp=01", pred_g); end
    drive_upd(2'b11, 11'd0, 11'd0, 2'b00, 2'b00);
    drive_upd(2'b11, 11'd0, 11'd0, 2'b00, 2'b00);
    drive_upd(2'b11, 11'd0, 11'd0, 2'b00, 2'b00);
    checks++;
    if (ghr_g !== 6'd0) begin errors++; $display("FAIL gsh_ghr0 got=%b exp=000000", ghr_g); end
    // Now lane0 pc8 -> entry 8 (1), lane1 pc11 -> entry 11 (3)
    checks++;
    if (pred_g !== 2'b10) begin errors++; $display("FAIL gsh_pred_ghr0 got=%b exp=10", pred_g); end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_bimodal();
    test_merge();
    test_ghr_order();
    test_gating();
    test_reset_mid();
    test_gshare();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
